// File: rtl/bomb_placer_if.sv
// bomb_placer_if: control and board-memory signals of the mine-placement engine.
interface bomb_placer_if #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int LFSR_W = 8
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);
    logic             start;
    logic [IDX_W:0]   num_bombs;
    logic [IDX_W-1:0] safe_idx;
    logic             seed_load;
    logic [LFSR_W-1:0] seed;
    logic             busy;
    logic             done;
    logic             error;
    logic             place_valid;
    logic [IDX_W-1:0] place_idx;
    logic [IDX_W:0]   placed_count;
    logic [CELLS-1:0] bomb_map;
    modport master (
        output start, num_bombs, safe_idx, seed_load, seed,
        input  busy, done, error, place_valid, place_idx, placed_count, bomb_map
    );
    modport slave (
        input  start, num_bombs, safe_idx, seed_load, seed,
        output busy, done, error, place_valid, place_idx, placed_count, bomb_map
    );
endinterface

// File: rtl/bomb_placer.sv
// bomb_placer: places distinct pseudo-random mines on a GRID_W x GRID_H board, never on the safe cell.
module bomb_placer #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int LFSR_W = 8,
    parameter logic [LFSR_W-1:0] SEED = '1
) (
    input logic clk,
    input logic rst,
    bomb_placer_if.slave bus
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);
    localparam int PAD = 2 ** IDX_W;
    localparam logic [LFSR_W-1:0] SEED_V = (SEED == '0) ? '1 : SEED;

    function automatic logic [15:0] taps(input int w);
        case (w)
            4:  return 16'h000C;
            5:  return 16'h0014;
            6:  return 16'h0030;
            7:  return 16'h0060;
            8:  return 16'h00B8;
            9:  return 16'h0110;
            10: return 16'h0240;
            11: return 16'h0500;
            12: return 16'h0829;
            13: return 16'h100D;
            14: return 16'h2015;
            15: return 16'h6000;
            16: return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [LFSR_W-1:0] TAP = LFSR_W'(taps(LFSR_W));

    // LFSR must be wider than the cell index so every index pattern appears within one period
    generate
        if (LFSR_W < IDX_W + 1 || LFSR_W < 4 || LFSR_W > 16) begin : g_bad_lfsr
            $error("bomb_placer: LFSR_W out of legal range");
        end
    endgenerate

    typedef enum logic {IDLE, PLACE} state_t;
    state_t state, state_n;
    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W:0]    target;
    logic [IDX_W-1:0]  safe_q;
    logic [IDX_W-1:0]  cand;
    logic [PAD-1:0]    map_pad;
    logic accept, last, bad, clr, done_n, error_n;

    assign cand    = lfsr[IDX_W-1:0];
    assign map_pad = PAD'(bus.bomb_map);
    assign accept  = state == PLACE && int'(cand) < CELLS && cand != safe_q && !map_pad[cand];
    assign last    = accept && bus.placed_count + 1'b1 == target;
    assign bad     = int'(bus.num_bombs) > CELLS - 1 || int'(bus.safe_idx) >= CELLS;
    assign bus.busy = state == PLACE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        done_n  = 1'b0;
        error_n = 1'b0;
        if (state == IDLE && bus.start) begin
            error_n = bad;
            clr     = !bad;
            done_n  = !bad && bus.num_bombs == '0;
            state_n = (!bad && bus.num_bombs != '0) ? PLACE : IDLE;
        end else if (last) begin
            done_n  = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr             <= SEED_V;
            target           <= '0;
            safe_q           <= '0;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
            bus.place_valid  <= 1'b0;
            bus.place_idx    <= '0;
            bus.placed_count <= '0;
            bus.bomb_map     <= '0;
        end else begin
            lfsr <= (state == IDLE && !bus.start && bus.seed_load) ? (bus.seed == '0 ? '1 : bus.seed)
                                                                    : {lfsr[LFSR_W-2:0], ^(lfsr & TAP)};
            bus.done        <= done_n;
            bus.error       <= error_n;
            bus.place_valid <= accept;
            if (clr) begin
                target           <= bus.num_bombs;
                safe_q           <= bus.safe_idx;
                bus.bomb_map     <= '0;
                bus.placed_count <= '0;
            end else if (accept) begin
                bus.bomb_map     <= bus.bomb_map | (CELLS'(1) << cand);
                bus.place_idx    <= cand;
                bus.placed_count <= bus.placed_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bomb_placer.sv
// tb_bomb_placer: randomized runs on 8x8 and 6x6 boards checked against a set-based placement model.
module tb_bomb_placer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0, start = 1'b0, seed_load = 1'b0;
    logic [6:0] nb = '0;
    logic [5:0] sidx = '0;
    logic [7:0] seed = '0;

    bomb_placer_if #(.GRID_W(8), .GRID_H(8), .LFSR_W(8)) b8();
    bomb_placer_if #(.GRID_W(6), .GRID_H(6), .LFSR_W(8)) b6();

    assign b8.start = start && !sel;
    assign b6.start = start && sel;
    assign b8.seed_load = seed_load && !sel;
    assign b6.seed_load = seed_load && sel;
    assign b8.num_bombs = nb;
    assign b6.num_bombs = nb;
    assign b8.safe_idx = sidx;
    assign b6.safe_idx = sidx;
    assign b8.seed = seed;
    assign b6.seed = seed;

    bomb_placer #(.GRID_W(8), .GRID_H(8), .LFSR_W(8)) d8 (.clk(clk), .rst(rst), .bus(b8));
    bomb_placer #(.GRID_W(6), .GRID_H(6), .LFSR_W(8)) d6 (.clk(clk), .rst(rst), .bus(b6));

    logic        busy, done, err, pv;
    logic [5:0]  pidx;
    logic [6:0]  pcnt;
    logic [63:0] map;
    assign busy = sel ? b6.busy : b8.busy;
    assign done = sel ? b6.done : b8.done;
    assign err  = sel ? b6.error : b8.error;
    assign pv   = sel ? b6.place_valid : b8.place_valid;
    assign pidx = sel ? b6.place_idx : b8.place_idx;
    assign pcnt = sel ? b6.placed_count : b8.placed_count;
    assign map  = sel ? 64'(b6.bomb_map) : b8.bomb_map;

    int n_chk = 0, n_fail = 0;
    int seq[$], save[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int n, input int s);
        @(negedge clk);
        nb = 7'(n);
        sidx = 6'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_seed(input logic [7:0] v);
        @(negedge clk);
        seed = v;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    function automatic int qdiff();
        int d = (seq.size() == save.size()) ? 0 : 1;
        for (int i = 0; i < seq.size() && i < save.size(); i++) d += (seq[i] != save[i]) ? 1 : 0;
        return d;
    endfunction

    // Model: accepted cells form a set of n distinct in-range cells avoiding the safe cell
    task automatic run(input int n, input int s, input int cells, input bit poke);
        int cyc = 0, badc = 0;
        bit seen[64];
        logic [63:0] exp_map = '0;
        seq.delete();
        pulse_start(n, s);
        chk("busy_rise", busy, 1);
        while (!done && cyc < n * 255 + 20) begin
            if (pv) begin
                seq.push_back(int'(pidx));
                chk("placed_count", pcnt, seq.size());
            end
            start = poke && cyc == 3;
            nb = poke ? 7'd1 : nb;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("last_valid", pv, 1);
        if (pv) seq.push_back(int'(pidx));
        chk("busy_fall", busy, 0);
        chk("final_count", pcnt, n);
        chk("latency_min", cyc >= n, 1);
        foreach (seq[i]) begin
            if (seq[i] >= cells || seq[i] == s || seen[seq[i]]) badc++;
            seen[seq[i]] = 1'b1;
            exp_map |= 64'(1) << seq[i];
        end
        chk("n_placed", seq.size(), n);
        chk("bad_cells", badc, 0);
        chk("map", map, exp_map);
        chk("popcount", $countones(map), n);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic expect_error(input int n, input int s);
        logic [63:0] m = map;
        pulse_start(n, s);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_done", done, 0);
        chk("err_map", map, m);
        @(negedge clk);
        chk("err_single", err, 0);
        chk("err_busy2", busy, 0);
    endtask

    initial begin
        int cyc, dn;
        repeat (3) @(negedge clk);
        chk("rst8", {b8.busy, b8.done, b8.error, b8.place_valid, b8.place_idx, b8.placed_count}, 0);
        chk("rst8_map", b8.bomb_map, 0);
        chk("rst6", {b6.busy, b6.done, b6.error, b6.place_valid, b6.place_idx, b6.placed_count}, 0);
        chk("rst6_map", 64'(b6.bomb_map), 0);
        rst = 1'b0;
        run(10, 27, 64, 0);
        expect_error(64, 5);
        run(63, 0, 64, 0);
        chk("full_map", map, 64'hFFFF_FFFF_FFFF_FFFE);
        load_seed(8'h5A);
        run(12, 9, 64, 0);
        save = seq;
        load_seed(8'h5A);
        run(12, 9, 64, 1);
        chk("repeat_seq", qdiff(), 0);
        load_seed(8'h00);
        run(12, 9, 64, 0);
        save = seq;
        load_seed(8'hFF);
        run(12, 9, 64, 0);
        chk("seed0_seq", qdiff(), 0);
        repeat (5) begin
            load_seed(8'($urandom));
            repeat ($urandom_range(0, 7)) @(negedge clk);
            run($urandom_range(1, 20), $urandom_range(0, 63), 64, 1'($urandom_range(0, 1)));
        end
        pulse_start(20, 3);
        cyc = 0;
        while (pcnt < 5 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached5", pcnt, 5);
        #1 rst = 1'b1;
        #1;
        chk("abort_out", {busy, done, err, pv, pidx, pcnt}, 0);
        chk("abort_map", map, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("abort_no_done", dn, 0);
        pulse_start(0, 0);
        chk("zero_done", done, 1);
        chk("zero_map", map, 0);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_single", done, 0);
        sel = 1'b1;
        run(35, 35, 36, 0);
        chk("map36", map, 64'h7_FFFF_FFFF);
        expect_error(10, 40);
        expect_error(36, 0);
        run($urandom_range(1, 20), $urandom_range(0, 35), 36, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
